// File: rtl/line_credit_feeder.sv
// line_credit_feeder
// Meters an 8-bit valid/ready pixel stream into a processing core that cannot
// stall. Each frame primes the core with PRIME_LINES lines. After that, one
// line is released for every line credit that the core returns on i_intr.
// Optional feature macro: LINE_FEEDER_PAD_EN. When it is defined, PAD_LINES
// all-zero lines are appended after the image so the core can flush its last
// output rows.
module line_credit_feeder #(
    parameter int IMG_WIDTH   = 512,
    parameter int IMG_HEIGHT  = 512,
    parameter int PRIME_LINES = 4,
    parameter int PAD_LINES   = 2
) (
    input  logic        axi_clk,
    input  logic        axi_reset_n,
    input  logic        i_start,
    input  logic        s_data_valid,
    input  logic [7:0]  s_data,
    output logic        s_data_ready,
    output logic        o_data_valid,
    output logic [7:0]  o_data,
    input  logic        i_intr,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [15:0] o_line_count
);

    localparam int               PIX_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(IMG_WIDTH - 1);
    localparam logic [15:0]      PRIME_END = 16'(PRIME_LINES);
`ifdef LINE_FEEDER_PAD_EN
    localparam logic [15:0]      IMAGE_END = 16'(IMG_HEIGHT);
    localparam logic [15:0]      FRAME_END = 16'(IMG_HEIGHT + PAD_LINES);
`else
    // Without padding the frame ends with the image; PAD_LINES has no effect here
    localparam logic [15:0]      IMAGE_END = 16'(IMG_HEIGHT + 0 * PAD_LINES);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        WAIT,
        LINE,
        PAD_WAIT,
        PAD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [15:0]      line_cnt_q, line_cnt_d;
    logic [2:0]       credit_q, credit_d;
    logic             intr_prev_q, intr_prev_d;
    logic             data_valid_q, data_valid_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic             xfer;
    logic             pix_step;
    logic             pix_wrap;
    logic             intr_edge;
    logic             launch;
    logic [15:0]      line_next;
    state_t           image_done_state;

    // The source may only move pixels while a line (or the prime) is open
    always_comb begin
        s_data_ready = (state_q == PRIME) || (state_q == LINE);
    end

    // Next-state, counter, credit and output-register computation
    always_comb begin
        xfer = s_data_valid && s_data_ready;
`ifdef LINE_FEEDER_PAD_EN
        pix_step = xfer || (state_q == PAD);
`else
        pix_step = xfer;
`endif
        pix_wrap  = pix_step && (pix_cnt_q == PIX_LAST);
        line_next = line_cnt_q + 16'd1;
        intr_edge = i_intr && !intr_prev_q && (state_q != IDLE);
        launch    = 1'b0;

`ifdef LINE_FEEDER_PAD_EN
        image_done_state = (IMAGE_END == FRAME_END) ? DONE : PAD_WAIT;
`else
        image_done_state = DONE;
`endif

        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        intr_prev_d  = i_intr;
        data_valid_d = 1'b0;
        data_d       = data_q;

        if (pix_step) begin
            pix_cnt_d = pix_wrap ? '0 : pix_cnt_q + PIX_W'(1);
        end
        if (pix_wrap) begin
            line_cnt_d = line_next;
        end

        if (xfer) begin
            data_valid_d = 1'b1;
            data_d       = s_data;
        end
`ifdef LINE_FEEDER_PAD_EN
        if (state_q == PAD) begin
            data_valid_d = 1'b1;
            data_d       = 8'd0;
        end
`endif

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = PRIME;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                end
            end
            PRIME: begin
                if (pix_wrap && (line_next == PRIME_END)) begin
                    state_d = (line_next == IMAGE_END) ? image_done_state : WAIT;
                end
            end
            WAIT: begin
                if (credit_q != 3'd0) begin
                    launch  = 1'b1;
                    state_d = LINE;
                end
            end
            LINE: begin
                if (pix_wrap) begin
                    state_d = (line_next == IMAGE_END) ? image_done_state : WAIT;
                end
            end
`ifdef LINE_FEEDER_PAD_EN
            PAD_WAIT: begin
                if (credit_q != 3'd0) begin
                    launch  = 1'b1;
                    state_d = PAD;
                end
            end
            PAD: begin
                if (pix_wrap) begin
                    state_d = (line_next == FRAME_END) ? DONE : PAD_WAIT;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        credit_d = credit_q;
        if ((state_q == IDLE) && i_start) begin
            credit_d = 3'd0;
        end else if (intr_edge && !launch) begin
            if (credit_q != 3'd7) begin
                credit_d = credit_q + 3'd1;
            end
        end else if (launch && !intr_edge) begin
            credit_d = credit_q - 3'd1;
        end

        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    // All state and registered outputs, cleared asynchronously
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            credit_q     <= '0;
            intr_prev_q  <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            credit_q     <= credit_d;
            intr_prev_q  <= intr_prev_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_data_valid = data_valid_q;
    assign o_data       = data_q;
    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;
    assign o_line_count = line_cnt_q;

endmodule

// File: tb/tb_line_credit_feeder.sv
// tb_line_credit_feeder
// Directed frame sequences, with randomized source stalls and pixel values,
// for line_credit_feeder. The reference model works at transaction level.
// Every accepted pixel must reappear one cycle later. The accepted count may
// never exceed the lines that prime and credits have paid for. Padding and
// frame totals are derived from the image geometry.
// Honours LINE_FEEDER_PAD_EN in the same way as the design.
module tb_line_credit_feeder;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int P    = 4;
    localparam int PADL = 2;

    logic        clk = 1'b0;
    logic        rstN;
    logic        iStart;
    logic        sValid;
    logic [7:0]  sData;
    logic        sReady;
    logic        oValid;
    logic [7:0]  oData;
    logic        iIntr;
    logic        oBusy;
    logic        oFrameDone;
    logic [15:0] oLineCount;

    int         assertCount = 0;
    int         failCount   = 0;
    logic [7:0] srcVal      = 8'd0;
    bit         randomSrc   = 1'b0;
    bit         prevIntr    = 1'b0;
    bit         lastReady   = 1'b0;
    int         acceptedFrame;
    int         padFrame;
    int         doneFrame;
    int         creditsFrame;
    int         cycleIdx    = 0;
    int         firstXfer;
    int         lastXfer;

    line_credit_feeder #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PRIME_LINES(P),
        .PAD_LINES  (PADL)
    ) dut (
        .axi_clk     (clk),
        .axi_reset_n (rstN),
        .i_start     (iStart),
        .s_data_valid(sValid),
        .s_data      (sData),
        .s_data_ready(sReady),
        .o_data_valid(oValid),
        .o_data      (oData),
        .i_intr      (iIntr),
        .o_busy      (oBusy),
        .o_frame_done(oFrameDone),
        .o_line_count(oLineCount)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any miss
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive the inputs, let the edge happen, then check the pipeline against the model
    task automatic applyStimulus(input bit valid, input bit intr, input bit start);
        bit         xfer;
        logic [7:0] sentVal;
        int         allowedLines;
        sValid = valid;
        sData  = srcVal;
        iIntr  = intr;
        iStart = start;
        if (intr && !prevIntr) creditsFrame++;
        prevIntr  = intr;
        lastReady = (sReady === 1'b1);
        xfer      = valid && (sReady === 1'b1);
        sentVal   = srcVal;
        @(posedge clk);
        #1;
        cycleIdx++;
        if (xfer) begin
            acceptedFrame++;
            if (firstXfer < 0) firstXfer = cycleIdx;
            lastXfer = cycleIdx;
            srcVal   = randomSrc ? 8'($urandom) : srcVal + 8'd1;
            checkOutput("outValid", oValid, 1);
            checkOutput("outData", oData, sentVal);
        end else begin
`ifdef LINE_FEEDER_PAD_EN
            if (oValid === 1'b1) begin
                padFrame++;
                checkOutput("padData", oData, 0);
            end else begin
                checkOutput("outValidIdle", oValid, 0);
            end
`else
            checkOutput("outValidIdle", oValid, 0);
`endif
        end
        if (oFrameDone === 1'b1) doneFrame++;
        allowedLines = (P + creditsFrame < H) ? P + creditsFrame : H;
        checkOutput("noOverrun", acceptedFrame <= allowedLines * W, 1);
    endtask

    // Clear the per-frame model state and issue the start pulse
    task automatic beginFrame(input bit rnd);
        randomSrc     = rnd;
        srcVal        = rnd ? 8'($urandom) : 8'd0;
        acceptedFrame = 0;
        padFrame      = 0;
        doneFrame     = 0;
        creditsFrame  = 0;
        firstXfer     = -1;
        lastXfer      = -1;
        applyStimulus(1'b1, 1'b0, 1'b1);
    endtask

    // Directed scenario sequence
    initial begin
        rstN   = 1'b0;
        iStart = 1'b0;
        sValid = 1'b0;
        sData  = 8'd0;
        iIntr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstReady", sReady, 0);
        checkOutput("rstValid", oValid, 0);
        checkOutput("rstData", oData, 0);
        checkOutput("rstBusy", oBusy, 0);
        checkOutput("rstDone", oFrameDone, 0);
        checkOutput("rstLines", oLineCount, 0);
        rstN = 1'b1;

        $display("[TB] frame 1: prime without credits, then one line per credit");
        beginFrame(1'b0);
        repeat (45) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("primeCount", acceptedFrame, P * W);
        checkOutput("primeReady", sReady, 0);
        checkOutput("primeLines", oLineCount, P);
        checkOutput("primeBusy", oBusy, 1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("startIgnored", oLineCount, P);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("creditReadyEarly", lastReady, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("creditReadyN2", lastReady, 1);
        repeat (15) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("line5Count", acceptedFrame, (P + 1) * W);
        checkOutput("line5Lines", oLineCount, P + 1);
        checkOutput("line5Ready", sReady, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (17) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("imageCount", acceptedFrame, H * W);
`ifdef LINE_FEEDER_PAD_EN
        checkOutput("padWaitBusy", oBusy, 1);
        checkOutput("padWaitDone", doneFrame, 0);
        repeat (PADL) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);
        end
        checkOutput("padPixels", padFrame, PADL * W);
        checkOutput("frameLines", oLineCount, H + PADL);
`else
        checkOutput("frameLines", oLineCount, H);
`endif
        checkOutput("frameDonePulses", doneFrame, 1);
        checkOutput("frameBusy", oBusy, 0);
        checkOutput("frameCount", acceptedFrame, H * W);

        $display("[TB] frame 2: three credits banked during the prime");
        beginFrame(1'b0);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, (i == 5) || (i == 7) || (i == 9), 1'b0);
        end
        checkOutput("burstCount", acceptedFrame, H * W);
        checkOutput("burstSpan", lastXfer - firstXfer, H * W + (H - P) - 1);
`ifdef LINE_FEEDER_PAD_EN
        checkOutput("burstPadFirst", padFrame, W);
        checkOutput("burstLinesMid", oLineCount, H + 1);
        checkOutput("burstBusyMid", oBusy, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("burstPadAll", padFrame, PADL * W);
        checkOutput("burstLines", oLineCount, H + PADL);
`else
        checkOutput("burstLines", oLineCount, H);
`endif
        checkOutput("burstDone", doneFrame, 1);
        checkOutput("burstBusy", oBusy, 0);

        $display("[TB] frame 3: random source, mid-line stall, reset mid-line");
        beginFrame(1'b1);
        for (int i = 0; i < 300 && acceptedFrame < P * W; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("randPrimeCount", acceptedFrame, P * W);
        checkOutput("randPrimeReady", sReady, 0);
        checkOutput("randPrimeLines", oLineCount, P);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("stallHold", acceptedFrame, P * W + 3);
        checkOutput("stallReady", sReady, 1);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("stallLineCount", acceptedFrame, (P + 1) * W);
        checkOutput("stallLines", oLineCount, P + 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("preResetValid", oValid, 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midRstReady", sReady, 0);
        checkOutput("midRstValid", oValid, 0);
        checkOutput("midRstData", oData, 0);
        checkOutput("midRstBusy", oBusy, 0);
        checkOutput("midRstDone", oFrameDone, 0);
        checkOutput("midRstLines", oLineCount, 0);
        @(posedge clk);
        #1;
        rstN     = 1'b1;
        prevIntr = 1'b0;

        $display("[TB] frame 4: prime replay after reset");
        beginFrame(1'b0);
        repeat (40) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("replayCount", acceptedFrame, P * W);
        checkOutput("replayLines", oLineCount, P);
        checkOutput("replayReady", sReady, 0);
        checkOutput("replayFirst", firstXfer >= 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
